// File: rtl/munoc_mni_pkg.sv
// Shared definitions for the MUNOC master-side NI: flit type codes, flit width helpers, FSM states.
package munoc_mni_pkg;

    localparam logic [1:0] FT_WR    = 2'b01;
    localparam logic [1:0] FT_RD    = 2'b10;
    localparam logic [1:0] FT_WDATA = 2'b11;
    localparam logic [1:0] FT_B     = 2'b01;
    localparam logic [1:0] FT_R     = 2'b10;

    typedef enum logic {StIdle, StWdata} mni_state_e;

    // Header: type, src, dst, tid, len(8), size(3), burst(2), addr.
    function automatic int unsigned hdr_width(int unsigned bw_addr, int unsigned bw_tid,
                                              int unsigned bw_node);
        return 2 + 2 * bw_node + bw_tid + 13 + bw_addr;
    endfunction

    function automatic int unsigned fflit_width(int unsigned bw_addr, int unsigned bw_data,
                                                int unsigned bw_tid, int unsigned bw_node);
        int unsigned h;
        int unsigned d;
        h = hdr_width(bw_addr, bw_tid, bw_node);
        d = 2 + bw_data + bw_data / 8;
        return (h > d) ? h : d;
    endfunction

    function automatic int unsigned bflit_width(int unsigned bw_tid, int unsigned bw_data);
        return 5 + bw_tid + bw_data;
    endfunction

endpackage

// File: rtl/munoc_master_ni_lite_if.sv
// AXI slave channels plus forward/backward NI links of the MUNOC master NI.
interface munoc_master_ni_lite_if
    import munoc_mni_pkg::*;
#(
    parameter int unsigned BW_ADDR = 32,
    parameter int unsigned BW_DATA = 32,
    parameter int unsigned BW_TID  = 4,
    parameter int unsigned BW_NODE = 4
);
    localparam int unsigned BW_FFLIT = fflit_width(BW_ADDR, BW_DATA, BW_TID, BW_NODE);
    localparam int unsigned BW_BFLIT = bflit_width(BW_TID, BW_DATA);

    logic                 s_awvalid, s_awready;
    logic [BW_TID-1:0]    s_awid;
    logic [BW_ADDR-1:0]   s_awaddr;
    logic [7:0]           s_awlen;
    logic [2:0]           s_awsize;
    logic [1:0]           s_awburst;
    logic                 s_wvalid, s_wready, s_wlast;
    logic [BW_DATA-1:0]   s_wdata;
    logic [BW_DATA/8-1:0] s_wstrb;
    logic                 s_bvalid, s_bready;
    logic [BW_TID-1:0]    s_bid;
    logic [1:0]           s_bresp;
    logic                 s_arvalid, s_arready;
    logic [BW_TID-1:0]    s_arid;
    logic [BW_ADDR-1:0]   s_araddr;
    logic [7:0]           s_arlen;
    logic [2:0]           s_arsize;
    logic [1:0]           s_arburst;
    logic                 s_rvalid, s_rready, s_rlast;
    logic [BW_TID-1:0]    s_rid;
    logic [BW_DATA-1:0]   s_rdata;
    logic [1:0]           s_rresp;
    logic                 fwd_valid, fwd_last, fwd_ready;
    logic [BW_FFLIT-1:0]  fwd_flit;
    logic                 bwd_valid, bwd_ready;
    logic [BW_BFLIT-1:0]  bwd_flit;

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
        output s_arready,
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        input  s_rready,
        output fwd_valid, fwd_flit, fwd_last,
        input  fwd_ready,
        input  bwd_valid, bwd_flit,
        output bwd_ready
    );

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bid, s_bresp,
        output s_bready,
        output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
        input  s_arready,
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
        output s_rready,
        input  fwd_valid, fwd_flit, fwd_last,
        output fwd_ready,
        output bwd_valid, bwd_flit,
        input  bwd_ready
    );

endinterface

// File: rtl/munoc_mni_resp_buf.sv
// One-entry valid/ready holding register; accepts a new entry in the cycle the old one drains.
module munoc_mni_resp_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/munoc_master_ni_lite.sv
// MUNOC master NI: packetizes AXI AW/W/AR onto the forward link, returns B/R from the backward link.
// Optional macro MUNOC_MNI_ERR_COUNT_EN adds a saturating err_cnt of SLVERR/DECERR responses.
module munoc_master_ni_lite
    import munoc_mni_pkg::*;
#(
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned BW_ADDR = 32,
    parameter int unsigned BW_DATA = 32,
    parameter int unsigned BW_TID  = 4,
    parameter int unsigned BW_NODE = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic clk,
    input  logic rst,
    munoc_master_ni_lite_if.slave bus,
`ifdef MUNOC_MNI_ERR_COUNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic err_sticky
);
    localparam int unsigned BW_FFLIT = fflit_width(BW_ADDR, BW_DATA, BW_TID, BW_NODE);
    localparam int unsigned BW_BFLIT = bflit_width(BW_TID, BW_DATA);

    mni_state_e          state_q, state_d;
    logic                rr_ar_q, rr_ar_d;  // set: AR wins the next AW/AR contest
    logic                fwd_valid_q, fwd_valid_d, fwd_last_q, fwd_last_d;
    logic [BW_FFLIT-1:0] fwd_flit_q, fwd_flit_d;
    logic [3:0]          wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                err_q;
    logic                out_free, aw_elig, ar_elig, aw_go, ar_go, w_go;
    logic                aw_hs, ar_hs, b_hs, r_hs, rl_hs;
    logic [BW_FFLIT-1:0] wr_hdr, rd_hdr, wdata_flit;

    assign out_free = !fwd_valid_q || bus.fwd_ready;
    assign aw_elig  = bus.s_awvalid && (wr_cnt_q < 4'(MAX_OUT));
    assign ar_elig  = bus.s_arvalid && (rd_cnt_q < 4'(MAX_OUT));

    assign wr_hdr = BW_FFLIT'({FT_WR, BW_NODE'(NODE_ID), bus.s_awaddr[BW_ADDR-1 -: BW_NODE],
                               bus.s_awid, bus.s_awlen, bus.s_awsize, bus.s_awburst,
                               bus.s_awaddr});
    assign rd_hdr = BW_FFLIT'({FT_RD, BW_NODE'(NODE_ID), bus.s_araddr[BW_ADDR-1 -: BW_NODE],
                               bus.s_arid, bus.s_arlen, bus.s_arsize, bus.s_arburst,
                               bus.s_araddr});
    assign wdata_flit = BW_FFLIT'({FT_WDATA, bus.s_wstrb, bus.s_wdata});

    always_comb begin
        state_d     = state_q;
        rr_ar_d     = rr_ar_q;
        fwd_valid_d = fwd_valid_q && !bus.fwd_ready;
        fwd_flit_d  = fwd_flit_q;
        fwd_last_d  = fwd_last_q;
        aw_go       = 1'b0;
        ar_go       = 1'b0;
        w_go        = 1'b0;
        case (state_q)
            StIdle: begin
                if (out_free) begin
                    if (aw_elig && (!ar_elig || !rr_ar_q)) begin
                        aw_go       = 1'b1;
                        fwd_valid_d = 1'b1;
                        fwd_flit_d  = wr_hdr;
                        fwd_last_d  = 1'b0;
                        state_d     = StWdata;
                    end else if (ar_elig) begin
                        ar_go       = 1'b1;
                        fwd_valid_d = 1'b1;
                        fwd_flit_d  = rd_hdr;
                        fwd_last_d  = 1'b1;
                    end
                    if (aw_elig && ar_elig) rr_ar_d = !rr_ar_q;
                end
            end
            StWdata: begin
                w_go = out_free;
                if (out_free && bus.s_wvalid) begin
                    fwd_valid_d = 1'b1;
                    fwd_flit_d  = wdata_flit;
                    fwd_last_d  = bus.s_wlast;
                    if (bus.s_wlast) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.s_awready = aw_go && !rst;
    assign bus.s_arready = ar_go && !rst;
    assign bus.s_wready  = w_go && !rst;
    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_flit  = fwd_flit_q;
    assign bus.fwd_last  = fwd_last_q;

    assign aw_hs = bus.s_awvalid && bus.s_awready;
    assign ar_hs = bus.s_arvalid && bus.s_arready;
    assign b_hs  = bus.s_bvalid && bus.s_bready;
    assign r_hs  = bus.s_rvalid && bus.s_rready;
    assign rl_hs = r_hs && bus.s_rlast;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs) wr_cnt_d = wr_cnt_q + 4'd1;
        else if (!aw_hs && b_hs) wr_cnt_d = wr_cnt_q - 4'd1;
        if (ar_hs && !rl_hs) rd_cnt_d = rd_cnt_q + 4'd1;
        else if (!ar_hs && rl_hs) rd_cnt_d = rd_cnt_q - 4'd1;
    end

    // Backward path: dispatch on flit type; unknown types are swallowed and flagged.
    logic [1:0]             bwd_type;
    logic                   bwd_is_b, bwd_is_r;
    logic                   b_in_ready, r_in_ready;
    logic [BW_TID+1:0]      b_out;
    logic [BW_BFLIT-3:0]    r_out;

    assign bwd_type      = bus.bwd_flit[BW_BFLIT-1 -: 2];
    assign bwd_is_b      = (bwd_type == FT_B);
    assign bwd_is_r      = (bwd_type == FT_R);
    assign bus.bwd_ready = !rst && (bwd_is_b ? b_in_ready : bwd_is_r ? r_in_ready : 1'b1);

    munoc_mni_resp_buf #(.Width(BW_TID + 2)) u_b_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.bwd_valid && bwd_is_b),
        .in_ready_o  (b_in_ready),
        .in_data_i   (bus.bwd_flit[BW_BFLIT-3 -: BW_TID+2]),
        .out_valid_o (bus.s_bvalid),
        .out_ready_i (bus.s_bready),
        .out_data_o  (b_out)
    );

    munoc_mni_resp_buf #(.Width(BW_BFLIT - 2)) u_r_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.bwd_valid && bwd_is_r),
        .in_ready_o  (r_in_ready),
        .in_data_i   (bus.bwd_flit[BW_BFLIT-3:0]),
        .out_valid_o (bus.s_rvalid),
        .out_ready_i (bus.s_rready),
        .out_data_o  (r_out)
    );

    assign bus.s_bid   = b_out[2 +: BW_TID];
    assign bus.s_bresp = b_out[1:0];
    assign bus.s_rid   = r_out[BW_DATA+3 +: BW_TID];
    assign bus.s_rresp = r_out[BW_DATA+1 +: 2];
    assign bus.s_rlast = r_out[BW_DATA];
    assign bus.s_rdata = r_out[BW_DATA-1:0];
    assign err_sticky  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ar_q     <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_flit_q  <= '0;
            fwd_last_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ar_q     <= rr_ar_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_flit_q  <= fwd_flit_d;
            fwd_last_q  <= fwd_last_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_q       <= err_q || (bus.bwd_valid && !bwd_is_b && !bwd_is_r);
        end
    end

`ifdef MUNOC_MNI_ERR_COUNT_EN
    logic [15:0] err_cnt_q;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_cnt_q} + 17'(b_hs && bus.s_bresp[1])
                   + 17'(r_hs && bus.s_rresp[1]);
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= (err_sum > 17'h0FFFF) ? 16'hFFFF : err_sum[15:0];
    end
`endif

endmodule
